memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 174 +++++++++++++++++
 tb/tb_memory_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// ============================================================================
// memory_stage
// ----------------------------------------------------------------------------
// Memory (M) stage of a 64-bit pipelined datapath.
//
// Contents:
//   - The E->M pipeline register, with synchronous reset, flush (bubble)
//     and stall (hold).
//   - A MEM_WORDS x 64-bit data memory. It is read combinationally and
//     written on the clock edge.
//   - Branch resolution (PCSrc_M) and qualification of the register write.
//
// Optional feature (compile-time macro):
//   MEM_ALIGN_CHECK_EN - when defined, accesses whose address is not 8-byte
//                        aligned are flagged on misaligned_M. A misaligned
//                        store is dropped, and a misaligned load returns 0.
//                        When undefined, misaligned_M is tied to 0 and the
//                        low three address bits are ignored.
//
// Parameters:
//   MEM_WORDS     - data memory depth in 64-bit words (power of two, >= 2)
//
// Ports:
//   clk           - rising-edge clock
//   reset         - synchronous active-high reset (register and memory)
//   stall_M       - hold the M register
//   flush_M       - load a bubble into the M register
//   valid_E       - execute-stage instruction valid
//   Branch_E      - conditional-branch control
//   MemRead_E     - load control
//   MemWrite_E    - store control
//   RegWrite_E    - register-file write control
//   writeReg_E    - destination register
//   PCBranch_E    - branch target
//   aluResult_E   - effective address or ALU result
//   writeData_E   - store data
//   zero_E        - ALU zero flag
//   PCSrc_M       - take branch
//   PCBranch_M    - registered branch target
//   aluResult_M   - registered ALU result
//   readData_M    - load data (0 when no load is active)
//   writeReg_M    - registered destination register
//   RegWrite_M    - qualified register write
//   valid_M       - M-stage instruction valid
//   misaligned_M  - access address not 8-byte aligned
// ============================================================================
module memory_stage #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_M,
    input  logic        flush_M,
    input  logic        valid_E,
    input  logic        Branch_E,
    input  logic        MemRead_E,
    input  logic        MemWrite_E,
    input  logic        RegWrite_E,
    input  logic [4:0]  writeReg_E,
    input  logic [63:0] PCBranch_E,
    input  logic [63:0] aluResult_E,
    input  logic [63:0] writeData_E,
    input  logic        zero_E,
    output logic        PCSrc_M,
    output logic [63:0] PCBranch_M,
    output logic [63:0] aluResult_M,
    output logic [63:0] readData_M,
    output logic [4:0]  writeReg_M,
    output logic        RegWrite_M,
    output logic        valid_M,
    output logic        misaligned_M
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    // M pipeline register fields
    logic        valid_m;
    logic        branch_m;
    logic        mem_read_m;
    logic        mem_write_m;
    logic        reg_write_m;
    logic [4:0]  write_reg_m;
    logic [63:0] pc_branch_m;
    logic [63:0] alu_result_m;
    logic [63:0] write_data_m;
    logic        zero_m;

    logic [63:0]      mem [MEM_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic             misaligned;
    logic             store_en;
    logic             load_en;

    // Priority is reset, then flush, then stall, then the normal load.
    // A flush only needs to kill valid and the control bits. The data
    // fields keep their old contents because nothing acts on them
    // without valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_m      <= 1'b0;
            branch_m     <= 1'b0;
            mem_read_m   <= 1'b0;
            mem_write_m  <= 1'b0;
            reg_write_m  <= 1'b0;
            write_reg_m  <= '0;
            pc_branch_m  <= '0;
            alu_result_m <= '0;
            write_data_m <= '0;
            zero_m       <= 1'b0;
        end else if (flush_M) begin
            valid_m      <= 1'b0;
            branch_m     <= 1'b0;
            mem_read_m   <= 1'b0;
            mem_write_m  <= 1'b0;
            reg_write_m  <= 1'b0;
        end else if (!stall_M) begin
            valid_m      <= valid_E;
            branch_m     <= Branch_E;
            mem_read_m   <= MemRead_E;
            mem_write_m  <= MemWrite_E;
            reg_write_m  <= RegWrite_E;
            write_reg_m  <= writeReg_E;
            pc_branch_m  <= PCBranch_E;
            alu_result_m <= aluResult_E;
            write_data_m <= writeData_E;
            zero_m       <= zero_E;
        end
    end

    // Upper address bits are dropped, so addresses wrap modulo MEM_WORDS*8.
    assign word_idx = alu_result_m[IDX_W+2:3];

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = valid_m & (mem_read_m | mem_write_m)
                        & (alu_result_m[2:0] != 3'b000);
`else
    assign misaligned = 1'b0;
`endif

    // The store is driven from the M register itself. A flush or stall
    // arriving on the same edge therefore cannot cancel it. A store
    // repeated during a stall writes the same word again, which is
    // harmless.
    assign store_en = valid_m & mem_write_m & ~misaligned;
    assign load_en  = valid_m & mem_read_m & ~misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (store_en) begin
            mem[word_idx] <= write_data_m;
        end
    end

    // The read is combinational from the array. A load that hits the
    // word being written in the same cycle therefore sees the pre-write
    // data.
    assign readData_M   = load_en ? mem[word_idx] : 64'd0;

    assign PCSrc_M      = valid_m & branch_m & zero_m;
    assign RegWrite_M   = valid_m & reg_write_m;
    assign valid_M      = valid_m;
    assign PCBranch_M   = pc_branch_m;
    assign aluResult_M  = alu_result_m;
    assign writeReg_M   = write_reg_m;
    assign misaligned_M = misaligned;

    // Address bits outside the word index have no function here.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, alu_result_m[63:IDX_W+3], alu_result_m[2:0]};

endmodule

// File: tb/tb_memory_stage.sv
// ============================================================================
// tb_memory_stage
// ----------------------------------------------------------------------------
// Directed, self-checking bench for memory_stage.
//
// Each vector drives the E-side inputs, waits one rising edge and then
// compares the M-side outputs 1 time unit later. Expected values are
// worked out by hand from the intended stage behaviour. The expectations
// for the alignment checks follow MEM_ALIGN_CHECK_EN.
// ============================================================================
module tb_memory_stage;

    localparam int MEM_WORDS = 64;

    logic        clk;
    logic        reset;
    logic        stall_M;
    logic        flush_M;
    logic        valid_E;
    logic        Branch_E;
    logic        MemRead_E;
    logic        MemWrite_E;
    logic        RegWrite_E;
    logic [4:0]  writeReg_E;
    logic [63:0] PCBranch_E;
    logic [63:0] aluResult_E;
    logic [63:0] writeData_E;
    logic        zero_E;
    logic        PCSrc_M;
    logic [63:0] PCBranch_M;
    logic [63:0] aluResult_M;
    logic [63:0] readData_M;
    logic [4:0]  writeReg_M;
    logic        RegWrite_M;
    logic        valid_M;
    logic        misaligned_M;

    int vec_count  = 0;
    int miss_count = 0;

    memory_stage #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_M      (stall_M),
        .flush_M      (flush_M),
        .valid_E      (valid_E),
        .Branch_E     (Branch_E),
        .MemRead_E    (MemRead_E),
        .MemWrite_E   (MemWrite_E),
        .RegWrite_E   (RegWrite_E),
        .writeReg_E   (writeReg_E),
        .PCBranch_E   (PCBranch_E),
        .aluResult_E  (aluResult_E),
        .writeData_E  (writeData_E),
        .zero_E       (zero_E),
        .PCSrc_M      (PCSrc_M),
        .PCBranch_M   (PCBranch_M),
        .aluResult_M  (aluResult_M),
        .readData_M   (readData_M),
        .writeReg_M   (writeReg_M),
        .RegWrite_M   (RegWrite_M),
        .valid_M      (valid_M),
        .misaligned_M (misaligned_M)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one instruction into E, then clock it into M.
    task automatic applyStimulus(input logic v, input logic br, input logic mr,
                                 input logic mw, input logic rw,
                                 input logic [4:0] wreg, input logic [63:0] pcb,
                                 input logic [63:0] alu, input logic [63:0] wd,
                                 input logic z);
        valid_E     = v;
        Branch_E    = br;
        MemRead_E   = mr;
        MemWrite_E  = mw;
        RegWrite_E  = rw;
        writeReg_E  = wreg;
        PCBranch_E  = pcb;
        aluResult_E = alu;
        writeData_E = wd;
        zero_E      = z;
        @(posedge clk);
        #1;
    endtask

    task automatic doLoad(input logic [63:0] addr);
        applyStimulus(1, 0, 1, 0, 1, 5'd3, 64'd0, addr, 64'd0, 0);
    endtask

    task automatic doStore(input logic [63:0] addr, input logic [63:0] data);
        applyStimulus(1, 0, 0, 1, 0, 5'd0, 64'd0, addr, data, 0);
    endtask

    task automatic doBubble();
        applyStimulus(0, 0, 0, 0, 0, 5'd0, 64'd0, 64'd0, 64'd0, 0);
    endtask

    logic        exp_mis_12;
    logic [63:0] exp_load_8;
    logic [63:0] exp_load_12;

    initial begin
`ifdef MEM_ALIGN_CHECK_EN
        exp_mis_12  = 1'b1;
        exp_load_8  = 64'd5;
        exp_load_12 = 64'd0;
`else
        exp_mis_12  = 1'b0;
        exp_load_8  = 64'hAB;
        exp_load_12 = 64'hAB;
`endif
        $display("[TB] memory_stage directed bench, MEM_WORDS=%0d", MEM_WORDS);

        // Reset for two cycles while junk sits on the E inputs.
        reset   = 1'b1;
        stall_M = 1'b0;
        flush_M = 1'b0;
        valid_E = 1'b1; Branch_E = 1'b1; MemRead_E = 1'b1; MemWrite_E = 1'b1;
        RegWrite_E = 1'b1; writeReg_E = 5'd7; PCBranch_E = 64'h123;
        aluResult_E = 64'h18; writeData_E = 64'h55; zero_E = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid",      {63'd0, valid_M},      64'd0);
        checkOutput("rst_pcsrc",      {63'd0, PCSrc_M},      64'd0);
        checkOutput("rst_regwrite",   {63'd0, RegWrite_M},   64'd0);
        checkOutput("rst_pcbranch",   PCBranch_M,            64'd0);
        checkOutput("rst_alu",        aluResult_M,           64'd0);
        checkOutput("rst_readdata",   readData_M,            64'd0);
        checkOutput("rst_writereg",   {59'd0, writeReg_M},   64'd0);
        checkOutput("rst_misaligned", {63'd0, misaligned_M}, 64'd0);
        reset = 1'b0;

        // Load of address 0 after reset returns 0.
        doLoad(64'd0);
        checkOutput("load0_valid",    {63'd0, valid_M},    64'd1);
        checkOutput("load0_data",     readData_M,          64'd0);
        checkOutput("load0_regwrite", {63'd0, RegWrite_M}, 64'd1);
        checkOutput("load0_wreg",     {59'd0, writeReg_M}, 64'd3);

        // Store then load, including an address that wraps.
        doStore(64'd16, 64'hDEAD_BEEF);
        checkOutput("st16_readdata", readData_M,          64'd0);
        checkOutput("st16_regwrite", {63'd0, RegWrite_M}, 64'd0);
        checkOutput("st16_alu",      aluResult_M,         64'd16);
        doLoad(64'd16);
        checkOutput("ld16_data", readData_M, 64'hDEAD_BEEF);
        doLoad(64'd16 + MEM_WORDS * 8);
        checkOutput("ldwrap_data", readData_M, 64'hDEAD_BEEF);
        checkOutput("ldwrap_alu",  aluResult_M, 64'd16 + MEM_WORDS * 8);

        // Read and write to the same word in one cycle: the read sees old data.
        applyStimulus(1, 0, 1, 1, 0, 5'd0, 64'd0, 64'd16, 64'h1111, 0);
        checkOutput("rmw_old_data", readData_M, 64'hDEAD_BEEF);
        doLoad(64'd16);
        checkOutput("rmw_new_data", readData_M, 64'h1111);

        // Branch resolution.
        applyStimulus(1, 1, 0, 0, 0, 5'd0, 64'h40, 64'd0, 64'd0, 1);
        checkOutput("br_taken_pcsrc", {63'd0, PCSrc_M}, 64'd1);
        checkOutput("br_taken_pcb",   PCBranch_M,       64'h40);
        doBubble();
        checkOutput("br_after_pcsrc", {63'd0, PCSrc_M}, 64'd0);
        applyStimulus(1, 1, 0, 0, 0, 5'd0, 64'h40, 64'd0, 64'd0, 0);
        checkOutput("br_nz_pcsrc", {63'd0, PCSrc_M}, 64'd0);
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 64'h40, 64'd0, 64'd0, 1);
        checkOutput("br_inv_pcsrc", {63'd0, PCSrc_M}, 64'd0);

        // Store 5 to address 8 and hold it with a 3-cycle stall while E changes.
        doStore(64'd8, 64'd5);
        stall_M = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 1, 0, 1, 5'd9, 64'h99, 64'd40, 64'd0, 1);
            checkOutput("stall_valid",    {63'd0, valid_M},    64'd1);
            checkOutput("stall_alu",      aluResult_M,         64'd8);
            checkOutput("stall_readdata", readData_M,          64'd0);
            checkOutput("stall_regwrite", {63'd0, RegWrite_M}, 64'd0);
            checkOutput("stall_pcsrc",    {63'd0, PCSrc_M},    64'd0);
        end
        stall_M = 1'b0;
        doLoad(64'd8);
        checkOutput("stall_mem1", readData_M, 64'd5);

        // Flush while a store of 7 to address 24 sits in E.
        flush_M = 1'b1;
        applyStimulus(1, 0, 0, 1, 1, 5'd4, 64'd0, 64'd24, 64'd7, 0);
        checkOutput("flush_valid",    {63'd0, valid_M},    64'd0);
        checkOutput("flush_regwrite", {63'd0, RegWrite_M}, 64'd0);
        checkOutput("flush_readdata", readData_M,          64'd0);
        flush_M = 1'b0;
        doLoad(64'd24);
        checkOutput("flush_mem3", readData_M, 64'd0);

        // A flush does not cancel a store already in M.
        doStore(64'd40, 64'd9);
        flush_M = 1'b1;
        doBubble();
        checkOutput("flushM_valid", {63'd0, valid_M}, 64'd0);
        flush_M = 1'b0;
        doLoad(64'd40);
        checkOutput("flushM_mem5", readData_M, 64'd9);

        // Store to an unaligned address.
        doStore(64'd12, 64'hAB);
        checkOutput("mis12_flag", {63'd0, misaligned_M}, {63'd0, exp_mis_12});
        doLoad(64'd8);
        checkOutput("mis_ld8_data", readData_M,            exp_load_8);
        checkOutput("mis_ld8_flag", {63'd0, misaligned_M}, 64'd0);
        doLoad(64'd12);
        checkOutput("mis_ld12_data", readData_M,            exp_load_12);
        checkOutput("mis_ld12_flag", {63'd0, misaligned_M}, {63'd0, exp_mis_12});

        // Reset during a stall clears the register and the memory.
        doLoad(64'd16);
        checkOutput("pre_rst_data", readData_M, 64'h1111);
        stall_M = 1'b1;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_stall_valid", {63'd0, valid_M}, 64'd0);
        checkOutput("rst_stall_alu",   aluResult_M,      64'd0);
        checkOutput("rst_stall_data",  readData_M,       64'd0);
        reset   = 1'b0;
        stall_M = 1'b0;
        doLoad(64'd16);
        checkOutput("rst_mem2_clear", readData_M, 64'd0);
        doLoad(64'd40);
        checkOutput("rst_mem5_clear", readData_M, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
